// File: rtl/count_pulse_debouncer_pkg.sv
// count_ctrl_pkg: shared state type and default timing constants for the counter's button front end
// Contents: dbnc_state_t, DEBOUNCE_CYCLES_DEF, REPEAT_CYCLES_DEF
package count_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} dbnc_state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_CYCLES_DEF   = 8;
endpackage

// File: rtl/count_pulse_debouncer_if.sv
// count_pulse_debouncer_if: button-side bundle between the pushbutton source and the debouncer
// Signals: btn_in (raw async button), count_pulse (one-cycle press pulse), btn_level (debounced level)
// Modports: master drives btn_in and observes outputs; slave is the debouncer
interface count_pulse_debouncer_if;
    logic btn_in;
    logic count_pulse;
    logic btn_level;
    modport master (output btn_in, input count_pulse, btn_level);
    modport slave  (input btn_in, output count_pulse, btn_level);
endinterface

// File: rtl/count_pulse_debouncer_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, reset to 0, for any asynchronous input
// Ports: clk, reset (sync, active-low), i_d (async in), o_q (synchronised out)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/count_pulse_debouncer.sv
// count_pulse_debouncer: turns a bouncy async pushbutton into a clean single-cycle count pulse
// Ports: clk, reset (sync, active-low), bus (count_pulse_debouncer_if.slave: btn_in in; count_pulse, btn_level out)
// Option: define AUTO_REPEAT_EN to emit a repeat pulse every REPEAT_CYCLES while the button is held
module count_pulse_debouncer
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef AUTO_REPEAT_EN
    , parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
    input logic clk,
    input logic reset,
    count_pulse_debouncer_if.slave bus
);
    localparam int TW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(DEBOUNCE_CYCLES - 1);
    dbnc_state_t r_state;
    dbnc_state_t w_state_nx;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nx;
    logic r_pulse;
    logic r_level;
    logic w_pulse_nx;
    logic w_btn_sync;
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_nx;
`endif
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.btn_in),
        .o_q   (w_btn_sync)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_pulse <= w_pulse_nx;
            r_level <= (w_state_nx == PRESSED) || (w_state_nx == RELEASE_WAIT);
        end
    end
`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset) r_rep <= '0;
        else        r_rep <= w_rep_nx;
    end
`endif
    // The timer defaults to 0, so any state change starts the next state with a clean count.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = '0;
        w_pulse_nx = 1'b0;
        case (r_state)
            IDLE: w_state_nx = w_btn_sync ? PRESS_WAIT : IDLE;
            PRESS_WAIT: begin
                if (!w_btn_sync) w_state_nx = IDLE;
                else if (r_timer == T_MAX) begin
                    w_state_nx = PRESSED;
                    w_pulse_nx = 1'b1;
                end else w_timer_nx = r_timer + 1'b1;
            end
            PRESSED: w_state_nx = w_btn_sync ? PRESSED : RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (w_btn_sync) w_state_nx = PRESSED;
                else if (r_timer == T_MAX) w_state_nx = IDLE;
                else w_timer_nx = r_timer + 1'b1;
            end
            default: w_state_nx = IDLE;
        endcase
`ifdef AUTO_REPEAT_EN
        // Only counts while staying in PRESSED; entry, exit and each repeat pulse restart it.
        w_rep_nx = '0;
        if (r_state == PRESSED && w_btn_sync) begin
            if (r_rep == R_MAX) w_pulse_nx = 1'b1;
            else w_rep_nx = r_rep + 1'b1;
        end
`endif
    end
    assign bus.count_pulse = r_pulse;
    assign bus.btn_level   = r_level;
endmodule

// File: tb/tb_count_pulse_debouncer.sv
// tb_count_pulse_debouncer: checks the debouncer against a run-length model and directed timing expectations
module tb_count_pulse_debouncer;
    localparam int D = 4;
    localparam int R = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] cnt = '0;
    int pulses_q[$];
    logic prev_p = 1'b0;
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_pls = 1'b0;
    int m_run = 0, m_held = 0;
    count_pulse_debouncer_if bus ();
    count_pulse_debouncer #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (!reset) cnt <= '0;
        else if (bus.count_pulse) cnt <= cnt + 1'b1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask
    // Model: the level flips once the synchronised button has disagreed with it for D+1 consecutive samples.
    always @(posedge clk) begin
        logic nl, np;
        int nr, nh;
        if (!reset) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_lvl <= 1'b0; m_pls <= 1'b0; m_run <= 0; m_held <= 0;
        end else begin
            nl = m_lvl; np = 1'b0; nh = m_held;
            nr = (m_s2 != m_lvl) ? m_run + 1 : 0;
            if (nr == D + 1) begin
                nl = !m_lvl; nr = 0; np = nl; nh = 0;
            end
`ifdef AUTO_REPEAT_EN
            else if (m_lvl) begin
                if (!m_s2) nh = -1;
                else begin
                    nh = m_held + 1;
                    if (nh == R) begin np = 1'b1; nh = 0; end
                end
            end
`endif
            m_s1 <= bus.btn_in; m_s2 <= m_s1; m_lvl <= nl; m_pls <= np; m_run <= nr; m_held <= nh;
        end
    end
    always @(negedge clk) begin
        chk("count_pulse", 32'(bus.count_pulse), 32'(m_pls));
        chk("btn_level", 32'(bus.btn_level), 32'(m_lvl));
        chk("pulse_gap", 32'(prev_p & bus.count_pulse), 32'd0);
        prev_p <= bus.count_pulse;
        if (bus.count_pulse === 1'b1) pulses_q.push_back(cyc);
    end
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int c0, base, at, p0;
        logic dropped;
        logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.btn_in = 1'b1;
        wait_cyc(3);
        chk("rst_pulse", 32'(bus.count_pulse), 0);
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_cnt", 32'(cnt), 0);
        base = pulses_q.size();
        reset = 1'b1;
        c0 = cyc;
        wait_cyc(12);
        chk("press_npulse", pulses_q.size() - base, 1);
        if (pulses_q.size() > base) chk("press_lat", pulses_q[base] - c0, 7);
        chk("press_cnt", 32'(cnt), 1);
        chk("press_level", 32'(bus.btn_level), 1);
        bus.btn_in = 1'b0;
        c0 = cyc;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            if (bus.btn_level == 1'b0) begin at = cyc; break; end
        end
        chk("release_lat", at - c0, 7);
        wait_cyc(4);
        base = pulses_q.size();
        foreach (pat[i]) begin
            bus.btn_in = pat[i];
            wait_cyc(1);
        end
        bus.btn_in = 1'b1;
        c0 = cyc;
        wait_cyc(12);
        chk("bounce_npulse", pulses_q.size() - base, 1);
        if (pulses_q.size() > base) chk("bounce_lat", pulses_q[base] - c0, 7);
        chk("bounce_cnt", 32'(cnt), 2);
        base = pulses_q.size();
        dropped = 1'b0;
        bus.btn_in = 1'b0;
        wait_cyc(2);
        bus.btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            if (bus.btn_level !== 1'b1) dropped = 1'b1;
        end
        chk("glitch_npulse", pulses_q.size() - base, 0);
        chk("glitch_level", 32'(dropped), 0);
        chk("glitch_cnt", 32'(cnt), 2);
        bus.btn_in = 1'b0;
        wait_cyc(12);
        reset = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        base = pulses_q.size();
        for (int i = 0; i < 16; i++) begin
            bus.btn_in = 1'b1;
            wait_cyc(8);
            bus.btn_in = 1'b0;
            wait_cyc(8);
            if (i == 14) chk("wrap_cnt15", 32'(cnt), 15);
        end
        wait_cyc(4);
        chk("wrap_npulse", pulses_q.size() - base, 16);
        chk("wrap_cnt0", 32'(cnt), 0);
        base = pulses_q.size();
        bus.btn_in = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);
        chk("abort_npulse", pulses_q.size() - base, 0);
        reset = 1'b1;
        c0 = cyc;
        wait_cyc(12);
        chk("held_rst_npulse", pulses_q.size() - base, 1);
        p0 = (pulses_q.size() > base) ? pulses_q[base] : -100;
        chk("held_rst_lat", p0 - c0, 7);
        wait_cyc(25);
`ifdef AUTO_REPEAT_EN
        chk("repeat_npulse", pulses_q.size() - base, 4);
        for (int k = 1; k < 4; k++)
            if (pulses_q.size() > base + k) chk("repeat_gap", pulses_q[base + k] - p0, 8 * k);
`else
        chk("repeat_npulse", pulses_q.size() - base, 1);
`endif
        bus.btn_in = 1'b0;
        wait_cyc(12);
        chk("final_level", 32'(bus.btn_level), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
